// File: rtl/luhn_pkg.sv
// Shared types for the Luhn mod-16 framer/checker pair.
package luhn_pkg;

    localparam int NIBBLE_W = 4;
    localparam int SIZE_W   = 8;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SIZE    = 2'd1,
        DATA    = 2'd2
    } framer_state_t;

endpackage

// File: rtl/luhn_nibble_buf.sv
// Nibble store: one or two nibble writes per cycle, registered read.
module luhn_nibble_buf
    import luhn_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          i_we,
    input  logic          i_two,
    input  logic [AW-1:0] i_waddr,
    input  nibble_t       i_hi,
    input  nibble_t       i_lo,
    input  logic          i_ren,
    input  logic [AW-1:0] i_raddr,
    output nibble_t       o_rd
);

    nibble_t       r_mem [DEPTH];
    nibble_t       r_rd;
    logic [AW-1:0] w_waddr1;

    assign w_waddr1 = i_waddr + AW'(1);
    assign o_rd     = r_rd;

    // Writes always start on an even slot, so the low nibble never wraps.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_hi;
            if (i_two) begin
                r_mem[w_waddr1] <= i_lo;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_rd <= '0;
        end else if (i_ren) begin
            r_rd <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/luhn_msg_framer.sv
// Store-and-forward framer: buffers a byte message as nibbles, then
// offers its nibble count followed by the nibbles themselves.
module luhn_msg_framer
    import luhn_pkg::*;
#(
    parameter  int MAX_NIBBLES = 64,
    localparam int AW          = $clog2(MAX_NIBBLES)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [7:0]        in_byte,
    input  logic              in_half,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SIZE_W-1:0] size,
    output logic              size_valid,
    input  logic              size_ready,
    output nibble_t           data,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              err
);

    framer_state_t     r_state;
    framer_state_t     w_state_nx;
    logic [SIZE_W-1:0] r_count;
    logic [SIZE_W-1:0] w_count_nx;
    logic [SIZE_W-1:0] r_rptr;
    logic [SIZE_W-1:0] w_rptr_nx;
    logic              r_ovf;
    logic              w_ovf_nx;
    logic              r_err;
    logic              w_err_nx;
    logic              r_in_ready;
    logic              w_in_xfer;
    logic              w_one;
    logic              w_fits;
    logic              w_we;
    logic              w_ren;
    logic [SIZE_W:0]   w_sum;
    logic [AW-1:0]     w_raddr;

    assign in_ready   = r_in_ready;
    assign size       = r_count;
    assign size_valid = (r_state == SIZE);
    assign data_valid = (r_state == DATA);
    assign err        = r_err;

    assign w_in_xfer = in_valid & r_in_ready;
    assign w_one     = in_half & in_last;
    assign w_sum     = {1'b0, r_count} + (w_one ? 9'd1 : 9'd2);
    assign w_fits    = !r_ovf && (w_sum <= (SIZE_W+1)'(MAX_NIBBLES));
    assign w_we      = w_in_xfer & w_fits;

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_rptr_nx  = r_rptr;
        w_ovf_nx   = r_ovf;
        w_err_nx   = 1'b0;
        w_ren      = 1'b0;
        w_raddr    = r_rptr[AW-1:0];
        unique case (r_state)
            COLLECT: begin
                if (w_in_xfer) begin
                    if (w_fits) begin
                        w_count_nx = w_sum[SIZE_W-1:0];
                    end else begin
                        w_ovf_nx = 1'b1;
                    end
                    if (in_last) begin
                        if (w_fits) begin
                            w_state_nx = SIZE;
                        end else begin
                            w_err_nx   = 1'b1;
                            w_count_nx = '0;
                            w_ovf_nx   = 1'b0;
                        end
                    end
                end
            end
            SIZE: begin
                // Prefetch nibble 0 so it is on data when data_valid rises.
                if (size_ready) begin
                    w_state_nx = DATA;
                    w_ren      = 1'b1;
                end
            end
            DATA: begin
                if (data_ready) begin
                    if (r_rptr == r_count - 8'd1) begin
                        w_state_nx = COLLECT;
                        w_count_nx = '0;
                        w_rptr_nx  = '0;
                    end else begin
                        w_rptr_nx = r_rptr + 8'd1;
                        w_ren     = 1'b1;
                        w_raddr   = w_rptr_nx[AW-1:0];
                    end
                end
            end
            default: begin
                w_state_nx = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state    <= COLLECT;
            r_count    <= '0;
            r_rptr     <= '0;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_count    <= w_count_nx;
            r_rptr     <= w_rptr_nx;
            r_ovf      <= w_ovf_nx;
            r_err      <= w_err_nx;
            r_in_ready <= (w_state_nx == COLLECT);
        end
    end

    luhn_nibble_buf #(
        .DEPTH (MAX_NIBBLES),
        .AW    (AW)
    ) u_buf (
        .clock   (clock),
        .rst     (rst),
        .i_we    (w_we),
        .i_two   (!w_one),
        .i_waddr (r_count[AW-1:0]),
        .i_hi    (in_byte[7:4]),
        .i_lo    (in_byte[3:0]),
        .i_ren   (w_ren),
        .i_raddr (w_raddr),
        .o_rd    (data)
    );

endmodule

// File: doc/luhn_msg_framer.md
Name: luhn_msg_framer

Overview:
- Upstream feeder for the Luhn mod-16 checker.
- Accepts a message as a byte stream with a last flag and buffers it as nibbles.
- Once the whole message is buffered, presents its nibble count on the size handshake, then streams the nibbles on the data handshake, high nibble of each byte first.
- Store-and-forward is mandatory because the checker needs the size before any data.

Parameters:
- MAX_NIBBLES, 64: buffer capacity in nibbles; legal range 2..255, even only.
- AW, $clog2(MAX_NIBBLES): buffer address width; derived, not overridden.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_byte  in  8  message byte; [7:4] is the earlier nibble.
- in_half  in  1  qualifies a beat with in_last: only [7:4] is used, [3:0] is ignored.
- in_last  in  1  final beat of the message.
- in_valid  in  1  input beat valid.
- in_ready  out  1  framer can accept a beat.
- size  out  8  nibble count of the buffered message.
- size_valid  out  1  size offered.
- size_ready  in  1  checker accepts size.
- data  out  4  current nibble.
- data_valid  out  1  nibble offered.
- data_ready  in  1  checker accepts nibble.
- err  out  1  one-cycle pulse: message exceeded MAX_NIBBLES and was discarded.

Behaviour:
- Handshake rule (all three interfaces): a transfer occurs on a rising edge where valid and ready are both 1.
  - Once asserted, valid and its payload stay stable until the transfer.
  - valid never depends combinationally on ready.
- Reset values: in_ready=0 during reset and 1 the cycle after release. size=0, size_valid=0, data=0, data_valid=0, err=0. Count, pointers and overflow flag are cleared.
- State COLLECT (in_ready=1):
  - Each accepted beat writes 2 nibbles, or 1 if in_half&in_last; count advances by the same amount.
  - in_half without in_last is ignored (treated as a full byte).
  - A beat that would make count exceed MAX_NIBBLES is dropped and sets the sticky ovf flag. Later beats are also dropped until in_last.
  - On an accepted in_last beat with ovf=0: go to SIZE. On the next cycle in_ready=0, size_valid=1, size=final count.
  - On an accepted in_last beat with ovf=1: err=1 for exactly the next cycle; count and ovf clear; stay in COLLECT.
- State SIZE: hold size_valid and size until transfer. On transfer go to DATA; the next cycle has data_valid=1 and data=nibble[0].
- State DATA:
  - Each transfer advances the read pointer; data shows the next nibble on the following cycle with data_valid still 1, so back-to-back transfers run at one per cycle.
  - After the transfer of nibble[count-1]: data_valid=0, count and pointers clear, return to COLLECT with in_ready=1 on the next cycle.
- Latency:
  - size_valid rises 1 cycle after the last input beat is accepted.
  - data_valid rises 1 cycle after the size transfer.
  - in_ready rises 1 cycle after the final data transfer.
- Counts: an 8-bit count is sufficient because MAX_NIBBLES ≤ 255. A zero-length message cannot occur, since every beat contributes at least one nibble.
- Exactly full: a message reaching exactly MAX_NIBBLES is legal and is not an overflow.
- Input during SIZE or DATA: in_ready=0, so no beat is accepted.
- Reset mid-operation: at any state, rst aborts the message and discards buffered nibbles; outputs take reset values the cycle after rst is sampled.
- Checker ready behaviour: size_ready/data_ready high while the corresponding valid is low has no effect.

Decomposition:
- Package luhn_pkg holds:
  - NIBBLE_W=4 and SIZE_W=8.
  - The framer state enum {COLLECT, SIZE, DATA}.
  - A shared nibble typedef also used by the checker.
- Sub-module luhn_nibble_buf: register array of MAX_NIBBLES nibbles.
  - Write port of 1 or 2 nibbles per cycle at the write pointer.
  - Registered read at the read pointer.
  - The framer owns count, the FSM and handshakes.

Test Plan:
- Basic 8-nibble message: bytes A3,DC,15,97 (last on 97), all readies held 1 → size=8; data A,3,D,C,1,5,9,7 on 8 consecutive cycles; in_ready back to 1 one cycle after the final transfer.
- Odd length: bytes 4C,A5,F0 with in_half&in_last on F0 → size=5, data 4,C,A,5,F; nibble 0 is never emitted.
- Backpressure: size_ready low for 5 cycles, then data_ready toggled randomly 0–8 cycles per nibble → size_valid and size=8 held stable, each nibble held until its transfer, order preserved, in_ready stays 0 throughout.
- Capacity edges (MAX_NIBBLES=8):
  - 4 bytes → size=8, no err.
  - 5 bytes → err pulses exactly once the cycle after the last beat; size_valid never asserts.
  - A following 2-byte message 12,34 → size=4, data 1,2,3,4.
- Reset mid-DATA: assert rst after 3 of 8 nibbles transferred → data_valid=0 and in_ready=0 the next cycle; in_ready=1 one cycle after release; a new message 7F (last) → size=2, data 7,F.
- Single half beat: byte B0 with in_half&in_last → size=1, data=B, then return to COLLECT.
